plic_claim_ctrl: RTL and testbench
==================================

# plic_claim_ctrl

Per-target claim/complete sequencer for the PLIC. Each cycle it masks pending sources with the target's enables, searches for the highest-priority pending source, and registers the winner. It raises the target interrupt when that priority exceeds the target threshold, and it arbitrates claim and complete requests from the target's register interface. It sits between the source gateways and the bus register block, with one instance per target.

## Interface
- `SOURCES`, 16, number of interrupt sources (IDs 1..SOURCES; ID 0 means none).
- `PRIORITIES`, 7, number of priority levels.
- `SOURCES_BITS`, `$clog2(SOURCES+1)`, ID width.
- `PRIORITY_BITS`, `$clog2(PRIORITIES)`, priority width.

- `rst_ni` input 1: asynchronous active-low reset.
- `clk_i` input 1: clock.
- `ip_i` input SOURCES: pending bits from the gateways. Bit k is ID k+1.
- `ie_i` input SOURCES: target enable bits.
- `priority_i` input PRIORITY_BITS x SOURCES: per-source priority.
- `threshold_i` input PRIORITY_BITS: target threshold.
- `claim_i` input 1: claim request, level.
- `claim_ack_o` output 1: one-cycle claim acknowledge.
- `claim_id_o` output SOURCES_BITS: claimed ID. Valid with `claim_ack_o`.
- `complete_i` input 1: complete strobe, one cycle.
- `complete_id_i` input SOURCES_BITS: ID being completed.
- `claimed_o` output SOURCES: one-hot pulse to the gateway. Clears pending.
- `completed_o` output SOURCES: one-hot pulse to the gateway. Re-arms the source.
- `irq_o` output 1: target interrupt request, registered.

## Operation
- **Search:** eff_pri[k] = (ip_i[k] & ie_i[k] & ~mask[k]) ? priority_i[k] : 0. The search is a combinational binary max-tree.
  - The higher index wins only on strictly greater priority, so ties go to the lowest ID.
  - The result registers into best_pri_q/best_id_q every cycle.
  - best_id_q = 0 when best_pri_q = 0.
- **irq_o:** registered (best_pri_q > threshold_i). Priority 0 never interrupts.
- **inservice_q[SOURCES]:** set on claim of ID n (bit n-1). Cleared on a valid complete.
- **FSM states:**
  - SCAN: search result is trusted.
  - SETTLE1, SETTLE2: gateway clear plus search pipeline refresh.
- **SCAN with claim_i=1:**
  - If best_pri_q > threshold_i: ID = best_id_q. Otherwise ID = 0.
  - Next cycle: claim_ack_o=1, claim_id_o=ID.
  - If ID≠0: claimed_o[ID-1] pulses and inservice bit ID-1 sets.
  - Go to SETTLE1, then SETTLE2, then SCAN.
- **claim_i in SETTLE1/SETTLE2:** held off, no ack. Serviced on return to SCAN.
- **Requester rule:** claim_i must drop in the ack cycle. If claim_i is still high after the ack, it counts as a new claim.
- **Complete:** accepted in any state.
  - complete_id_i in 1..SOURCES with inservice set: next cycle completed_o pulses and the bit clears.
  - ID 0, out-of-range ID, or not in-service: ignored, no pulse.
- **Claim and complete in the same cycle:** both are processed. A complete evaluates inservice before that cycle's claim update, so completing the ID being claimed in the same cycle is ignored.
- **Reset mid-operation:** FSM returns to SCAN, inservice clears, any pending ack is dropped.

## Timing
- Reset values:
  - Outputs: `claim_ack_o`=0, `claim_id_o`=0, `claimed_o`=0, `completed_o`=0, `irq_o`=0.
  - Internal: best_pri_q=0, best_id_q=0, FSM=SCAN.
- Source change to irq_o: 2 cycles (search register, then irq register).
- claim_i to claim_ack_o: 1 cycle in SCAN. Worst case 3 cycles when claim_i arrives in SETTLE1.
- Back-to-back claims: minimum 3-cycle spacing between acks.
- complete_i to completed_o: 1 cycle.
- All pulse outputs are exactly one cycle wide and registered.

## Configuration
- `PLIC_INSERVICE_MASK_EN` defined: mask = inservice_q. Claimed, not-yet-completed sources are excluded from the search even if re-pended.
- `PLIC_INSERVICE_MASK_EN` undefined: mask = 0. In-service tracking still gates `completed_o`, but the search ignores it.

## Test plan
- **Basic claim:** ID3 pri 5, ID7 pri 2, threshold 1, all enabled.
  - irq_o=1 two cycles after pend.
  - Claim: claim_id_o=3, claimed_o[2] pulse.
  - After settle, next claim returns 7.
- **Tie:** IDs 4 and 9 both pri 3 → claim returns 4.
- **Threshold:** ID5 pri 2, threshold 2.
  - irq_o stays 0.
  - Claim: ack with ID 0, no claimed_o.
- **Held claim:** claim_i held high through the ack → second ack exactly 3 cycles later.
- **Complete:**
  - Complete ID3 after claiming 3 → completed_o[2] next cycle.
  - Repeat complete of ID3, or complete of ID 0 or 20 → no pulse.
  - Claim and complete of the same ID in one cycle → complete ignored.
- **Mask build, source re-pends while in-service:**
  - With `PLIC_INSERVICE_MASK_EN`: claim returns 0 until the source completes.
  - Without it: claim returns the source again.
  - Reset asserted in SETTLE1 → all outputs 0, next claim accepted with 1-cycle latency.

Source files
------------

// File: rtl/plic_claim_ctrl.sv
// Purpose : per-target PLIC claim/complete sequencer with max-priority search and irq generation.
// Latency : sources->irq_o 2 cycles; claim_i->claim_ack_o 1 cycle in SCAN (3 worst case); complete_i->completed_o 1 cycle.
// Backpress: claims are held off for two settle cycles after each ack; completes are always accepted.
// Build option: define PLIC_INSERVICE_MASK_EN to exclude in-service sources from the search.
module plic_claim_ctrl #(
  parameter int SOURCES       = 16,
  parameter int PRIORITIES    = 7,
  parameter int SOURCES_BITS  = $clog2(SOURCES + 1),
  parameter int PRIORITY_BITS = $clog2(PRIORITIES)
) (
  input  logic                               rst_ni,
  input  logic                               clk_i,
  input  logic [SOURCES-1:0]                 ip_i,
  input  logic [SOURCES-1:0]                 ie_i,
  input  logic [SOURCES*PRIORITY_BITS-1:0]   priority_i,
  input  logic [PRIORITY_BITS-1:0]           threshold_i,
  input  logic                               claim_i,
  output logic                               claim_ack_o,
  output logic [SOURCES_BITS-1:0]            claim_id_o,
  input  logic                               complete_i,
  input  logic [SOURCES_BITS-1:0]            complete_id_i,
  output logic [SOURCES-1:0]                 claimed_o,
  output logic [SOURCES-1:0]                 completed_o,
  output logic                               irq_o
);

  // Search tree is padded up to a power of two; padding leaves never win.
  localparam int LEVELS = (SOURCES > 1) ? $clog2(SOURCES) : 1;
  localparam int NLEAF  = 1 << LEVELS;

  // SETTLE1/SETTLE2 give the gateway time to drop the claimed source and
  // the search register time to reflect that before the next claim.
  typedef enum logic [1:0] {SCAN, SETTLE1, SETTLE2} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [PRIORITY_BITS-1:0]   r_best_pri;
  logic [SOURCES_BITS-1:0]    r_best_id;
  logic                       r_irq;
  logic                       r_claim_ack;
  logic [SOURCES_BITS-1:0]    r_claim_id;
  logic [SOURCES-1:0]         r_claimed;
  logic [SOURCES-1:0]         r_completed;
  logic [SOURCES-1:0]         r_inservice;

  logic [SOURCES-1:0]         w_mask;
  logic [PRIORITY_BITS-1:0]   w_best_pri;
  logic [SOURCES_BITS-1:0]    w_best_id;
  logic                       w_claim_go;
  logic [SOURCES_BITS-1:0]    w_claim_id;
  logic [SOURCES-1:0]         w_claim_oh;
  logic [SOURCES-1:0]         w_cmp_oh;
  logic [SOURCES-1:0]         w_inservice_nxt;

`ifdef PLIC_INSERVICE_MASK_EN
  assign w_mask = r_inservice;
`else
  assign w_mask = '0;
`endif

  // Binary max-tree: leaves are ordered by ID, and the right (higher-ID)
  // child only wins on strictly greater priority, so ties go to the lower ID.
  for (genvar lv = 0; lv <= LEVELS; lv++) begin : g_lvl
    localparam int N = NLEAF >> lv;
    logic [N-1:0][PRIORITY_BITS-1:0] w_pri;
    logic [N-1:0][SOURCES_BITS-1:0]  w_id;
    for (genvar n = 0; n < N; n++) begin : g_node
      if (lv == 0) begin : g_leaf
        if (n < SOURCES) begin : g_src
          assign w_pri[n] = (ip_i[n] & ie_i[n] & ~w_mask[n]) ?
                            priority_i[n*PRIORITY_BITS +: PRIORITY_BITS] : '0;
          assign w_id[n]  = SOURCES_BITS'(n + 1);
        end else begin : g_pad
          assign w_pri[n] = '0;
          assign w_id[n]  = '0;
        end
      end else begin : g_cmp
        logic w_right_wins;
        assign w_right_wins = g_lvl[lv-1].w_pri[2*n+1] > g_lvl[lv-1].w_pri[2*n];
        assign w_pri[n] = w_right_wins ? g_lvl[lv-1].w_pri[2*n+1] : g_lvl[lv-1].w_pri[2*n];
        assign w_id[n]  = w_right_wins ? g_lvl[lv-1].w_id[2*n+1]  : g_lvl[lv-1].w_id[2*n];
      end
    end
  end

  assign w_best_pri = g_lvl[LEVELS].w_pri[0];
  assign w_best_id  = g_lvl[LEVELS].w_id[0];

  // Claim only hands out an ID that would actually raise the interrupt.
  assign w_claim_id = (r_best_pri > threshold_i) ? r_best_id : '0;

  // Next-state logic: a claim is only serviced in SCAN, then the FSM settles for two cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_claim_go  = 1'b0;
    case (r_state)
      SCAN: begin
        if (claim_i) begin
          w_claim_go  = 1'b1;
          w_state_nxt = SETTLE1;
        end
      end
      SETTLE1: w_state_nxt = SETTLE2;
      SETTLE2: w_state_nxt = SCAN;
      default: w_state_nxt = SCAN;
    endcase
  end

  // One-hot claim/complete decode; completes test in-service before this cycle's claim sets it.
  always_comb begin
    w_claim_oh = '0;
    w_cmp_oh   = '0;
    for (int k = 0; k < SOURCES; k++) begin
      w_claim_oh[k] = w_claim_go && (w_claim_id == SOURCES_BITS'(k + 1));
      w_cmp_oh[k]   = complete_i && (complete_id_i == SOURCES_BITS'(k + 1)) && r_inservice[k];
    end
    w_inservice_nxt = (r_inservice & ~w_cmp_oh) | w_claim_oh;
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= SCAN;
    else         r_state <= w_state_nxt;
  end

  // Search result and interrupt pipeline; ID is forced to 0 when nothing qualifies.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_best_pri <= '0;
      r_best_id  <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_best_pri <= w_best_pri;
      r_best_id  <= (w_best_pri == '0) ? '0 : w_best_id;
      r_irq      <= (r_best_pri > threshold_i);
    end
  end

  // Registered single-cycle pulses and in-service tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_claim_ack <= 1'b0;
      r_claim_id  <= '0;
      r_claimed   <= '0;
      r_completed <= '0;
      r_inservice <= '0;
    end else begin
      r_claim_ack <= w_claim_go;
      r_claim_id  <= w_claim_go ? w_claim_id : '0;
      r_claimed   <= w_claim_oh;
      r_completed <= w_cmp_oh;
      r_inservice <= w_inservice_nxt;
    end
  end

  assign claim_ack_o = r_claim_ack;
  assign claim_id_o  = r_claim_id;
  assign claimed_o   = r_claimed;
  assign completed_o = r_completed;
  assign irq_o       = r_irq;

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// Directed and randomized bench for plic_claim_ctrl against a behavioural model.
module tb_plic_claim_ctrl;
  localparam int S  = 16;
  localparam int PB = 3;
  localparam int SB = 5;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [S-1:0]  ip_i = '0;
  logic [S-1:0]  ie_i = '0;
  logic [S*PB-1:0] priority_i = '0;
  logic [PB-1:0] threshold_i = '0;
  logic          claim_i = 1'b0;
  logic          claim_ack_o;
  logic [SB-1:0] claim_id_o;
  logic          complete_i = 1'b0;
  logic [SB-1:0] complete_id_i = '0;
  logic [S-1:0]  claimed_o;
  logic [S-1:0]  completed_o;
  logic          irq_o;

  int checks = 0;
  int errors = 0;

  bit m_ip [1:S];
  bit m_ie [1:S];
  bit m_insvc [1:S];
  int m_pri [1:S];
  int m_thr;

  always #5 clk_i = ~clk_i;

  plic_claim_ctrl dut (
    .rst_ni(rst_ni), .clk_i(clk_i), .ip_i(ip_i), .ie_i(ie_i),
    .priority_i(priority_i), .threshold_i(threshold_i),
    .claim_i(claim_i), .claim_ack_o(claim_ack_o), .claim_id_o(claim_id_o),
    .complete_i(complete_i), .complete_id_i(complete_id_i),
    .claimed_o(claimed_o), .completed_o(completed_o), .irq_o(irq_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [S-1:0] oh(input int id);
    logic [S-1:0] v;
    v = '0;
    if (id >= 1 && id <= S) v[id-1] = 1'b1;
    return v;
  endfunction

  // Highest priority among pending & enabled sources, lowest ID on ties.
  function automatic void model_best(output int bp, output int bid);
    bit masked;
    bp = 0;
    bid = 0;
    for (int k = 1; k <= S; k++) begin
`ifdef PLIC_INSERVICE_MASK_EN
      masked = m_insvc[k];
`else
      masked = 1'b0;
`endif
      if (m_ip[k] && m_ie[k] && !masked && m_pri[k] > bp) begin
        bp = m_pri[k];
        bid = k;
      end
    end
  endfunction

  function automatic int exp_claim();
    int bp, bid;
    model_best(bp, bid);
    return (bp > m_thr) ? bid : 0;
  endfunction

  function automatic logic exp_irq();
    int bp, bid;
    model_best(bp, bid);
    return (bp > m_thr);
  endfunction

  task automatic apply();
    for (int k = 1; k <= S; k++) begin
      ip_i[k-1] = m_ip[k];
      ie_i[k-1] = m_ie[k];
      priority_i[(k-1)*PB +: PB] = PB'(m_pri[k]);
    end
    threshold_i = PB'(m_thr);
  endtask

  task automatic clear_model();
    for (int k = 1; k <= S; k++) begin
      m_ip[k] = 1'b0;
      m_ie[k] = 1'b1;
      m_pri[k] = 0;
    end
    m_thr = 0;
  endtask

  // Issue one claim from SCAN, check the ack cycle, then ride out the settle cycles.
  task automatic do_claim(input int want, input bit gw_clear);
    claim_i = 1'b1;
    tick();
    claim_i = 1'b0;
    check("claim_ack", claim_ack_o, 1);
    check("claim_id", claim_id_o, want);
    check("claimed_oh", claimed_o, oh(want));
    if (want != 0) begin
      m_insvc[want] = 1'b1;
      if (gw_clear) begin
        m_ip[want] = 1'b0;
        apply();
      end
    end
    tick();
    check("claim_ack_width", claim_ack_o, 0);
    check("claimed_width", claimed_o, 0);
    tick();
  endtask

  task automatic do_complete(input int id);
    bit v;
    v = (id >= 1 && id <= S) ? m_insvc[id] : 1'b0;
    complete_i = 1'b1;
    complete_id_i = SB'(id);
    tick();
    complete_i = 1'b0;
    check("completed_oh", completed_o, v ? oh(id) : '0);
    if (v) m_insvc[id] = 1'b0;
    tick();
    check("completed_width", completed_o, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"}, claim_ack_o, 0);
    check({tag, "_id"}, claim_id_o, 0);
    check({tag, "_claimed"}, claimed_o, 0);
    check({tag, "_completed"}, completed_o, 0);
    check({tag, "_irq"}, irq_o, 0);
  endtask

  initial begin
    for (int k = 1; k <= S; k++) m_insvc[k] = 1'b0;
    clear_model();
    apply();
    tick();
    tick();
    rst_ni = 1'b1;
    check_outputs_zero("reset");

    // Basic claim: ID3 pri 5, ID7 pri 2, threshold 1.
    clear_model();
    m_pri[3] = 5; m_pri[7] = 2; m_ip[3] = 1; m_ip[7] = 1; m_thr = 1;
    apply();
    tick();
    check("irq_lat1", irq_o, 0);
    tick();
    check("irq_lat2", irq_o, 1);
    do_claim(3, 1);
    do_claim(7, 1);
    do_complete(3);
    do_complete(3);
    do_complete(0);
    do_complete(20);
    do_complete(7);

    // Tie between IDs 4 and 9.
    clear_model();
    m_pri[4] = 3; m_pri[9] = 3; m_ip[4] = 1; m_ip[9] = 1; m_thr = 1;
    apply();
    tick(); tick();
    do_claim(4, 1);
    do_complete(4);

    // Threshold equal to priority: no interrupt, claim returns 0.
    clear_model();
    m_pri[5] = 2; m_ip[5] = 1; m_thr = 2;
    apply();
    tick(); tick();
    check("thr_irq", irq_o, 0);
    do_claim(0, 1);

    // Claim held through the ack: next ack exactly 3 cycles later.
    clear_model();
    apply();
    tick(); tick();
    claim_i = 1'b1;
    tick();
    check("held_ack0", claim_ack_o, 1);
    tick();
    check("held_gap1", claim_ack_o, 0);
    tick();
    check("held_gap2", claim_ack_o, 0);
    tick();
    check("held_ack1", claim_ack_o, 1);
    check("held_id", claim_id_o, 0);
    claim_i = 1'b0;
    tick();
    check("held_after", claim_ack_o, 0);
    tick();

    // Claim and complete of the same ID in one cycle: complete is ignored.
    clear_model();
    m_pri[6] = 4; m_ip[6] = 1; m_thr = 0;
    apply();
    tick(); tick();
    claim_i = 1'b1;
    complete_i = 1'b1;
    complete_id_i = SB'(6);
    tick();
    claim_i = 1'b0;
    complete_i = 1'b0;
    check("same_ack", claim_ack_o, 1);
    check("same_id", claim_id_o, 6);
    check("same_claimed", claimed_o, oh(6));
    check("same_completed", completed_o, 0);
    m_insvc[6] = 1'b1;
    m_ip[6] = 1'b0;
    apply();
    tick();
    check("same_completed_late", completed_o, 0);
    tick();
    do_complete(6);

    // Source re-pends while in service.
    clear_model();
    m_pri[2] = 3; m_ip[2] = 1; m_thr = 0;
    apply();
    tick(); tick();
    do_claim(2, 1);
    m_ip[2] = 1'b1;
    apply();
    tick(); tick();
`ifdef PLIC_INSERVICE_MASK_EN
    do_claim(0, 0);
`else
    do_claim(2, 0);
`endif
    do_complete(2);
    tick(); tick();
    do_claim(2, 1);
    do_complete(2);

    // Reset asserted in SETTLE1.
    clear_model();
    m_pri[3] = 5; m_ip[3] = 1; m_thr = 1;
    apply();
    tick(); tick();
    claim_i = 1'b1;
    tick();
    claim_i = 1'b0;
    check("rst_pre_ack", claim_ack_o, 1);
    #2 rst_ni = 1'b0;
    #2 check_outputs_zero("midrst");
    #2 rst_ni = 1'b1;
    for (int k = 1; k <= S; k++) m_insvc[k] = 1'b0;
    tick();
    do_claim(3, 1);
    do_complete(3);

    // Randomized phase against the model.
    for (int it = 0; it < 200; it++) begin
      for (int k = 1; k <= S; k++) begin
        m_ip[k] = 1'($urandom_range(0, 1));
        m_ie[k] = 1'($urandom_range(0, 1));
        m_pri[k] = int'($urandom_range(0, 6));
      end
      m_thr = int'($urandom_range(0, 6));
      apply();
      tick(); tick();
      check("rnd_irq", irq_o, exp_irq());
      if ($urandom_range(0, 1) == 1) do_claim(exp_claim(), 0);
      if ($urandom_range(0, 2) != 0) do_complete(int'($urandom_range(0, 20)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
